// File: rtl/dcf77_regfile_pkg.sv
// Shared frame type, register offsets and status/control bit positions for the
// DCF77 Wishbone register file.
package dcf77_pkg;

  typedef logic [63:0] dcf77_frame_t;

  localparam int STAT_NEW_FRAME_BIT = 0;
  localparam int STAT_OVERRUN_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT    = 0;

  function automatic int status_offset(input int words);
    return 2 * words;
  endfunction

  function automatic int ctrl_offset(input int words);
    return (2 * words) + 1;
  endfunction

endpackage

// File: rtl/dcf77_regfile_snapshot.sv
// Per-frame shadow register: captures a 64-bit frame on load and serves it
// back one DATA_W-wide word at a time (word 0 = most significant slice).
module dcf77_frame_snapshot
  import dcf77_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WORDS  = 64 / DATA_W,
  parameter int SEL_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  dcf77_frame_t      frame_in,
  input  logic [SEL_W-1:0]  word_sel,
  output logic [DATA_W-1:0] word_out
);

  logic [WORDS-1:0][DATA_W-1:0] shadow_r;

  // Capture the whole frame at once so later word reads see one coherent sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= '0;
    end else if (load) begin
      shadow_r <= frame_in;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Word 0 lives in the top element; WORDS is a power of two, so ~sel maps it.
  assign word_out = shadow_r[~word_sel];

endmodule

// File: rtl/dcf77_regfile.sv
// Wishbone register file exposing the decoded DCF77 frame, the local clock frame,
// sticky STATUS and CTRL. Optional new-frame interrupt: define DCF77_REGFILE_IRQ_EN.
module dcf77_regfile
  import dcf77_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int AUTO_INC = 0,
  localparam int WORDS    = 64 / DATA_W,
  localparam int ADR_W    = $clog2(2 * WORDS + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  input  dcf77_frame_t      dcf77_frame_i,
  input  logic              dcf77_valid_i,
  input  dcf77_frame_t      clock_frame_i
`ifdef DCF77_REGFILE_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int SEL_W = $clog2(WORDS);
  localparam logic [ADR_W-1:0] CLK_BASE_A = ADR_W'(WORDS);
  localparam logic [ADR_W-1:0] STATUS_A   = ADR_W'(status_offset(WORDS));
  localparam logic [ADR_W-1:0] CTRL_A     = ADR_W'(ctrl_offset(WORDS));
  localparam logic [SEL_W-1:0] WORD0      = '0;

  logic              ack_r;
  logic [DATA_W-1:0] dat_r;
  logic              new_frame_r;
  logic              overrun_r;
  logic              irq_en_s;
  logic [SEL_W-1:0]  ptr_r;

  logic              req_s;
  logic              rd_s;
  logic              wr_s;
  logic              sel_dcf_s;
  logic              sel_clk_s;
  logic              sel_stat_s;
  logic              sel_ctrl_s;
  logic [SEL_W-1:0]  word_s;
  logic [DATA_W-1:0] dcf_word_s;
  logic [DATA_W-1:0] clk_word_s;
  logic [DATA_W-1:0] rdata_s;
  logic              dcf_load_s;
  logic              clk_load_s;
  logic              stat_clr_s;
  logic              unused_s;

  // A new access only starts while ack is low, which forbids back-to-back acks.
  assign req_s = wb_cyc_i & wb_stb_i & ~ack_r;
  assign rd_s  = req_s & ~wb_we_i;
  assign wr_s  = req_s & wb_we_i;

  // Address decode; in sequential mode reads always target the DCF77 frame at the pointer.
  always_comb begin
    sel_dcf_s  = 1'b0;
    sel_clk_s  = 1'b0;
    sel_stat_s = 1'b0;
    sel_ctrl_s = 1'b0;
    word_s     = wb_adr_i[SEL_W-1:0];
    if ((AUTO_INC != 0) && !wb_we_i) begin
      sel_dcf_s = 1'b1;
      word_s    = ptr_r;
    end else if (wb_adr_i < CLK_BASE_A) begin
      sel_dcf_s = 1'b1;
    end else if (wb_adr_i < STATUS_A) begin
      sel_clk_s = 1'b1;
    end else if (wb_adr_i == STATUS_A) begin
      sel_stat_s = 1'b1;
    end else if (wb_adr_i == CTRL_A) begin
      sel_ctrl_s = 1'b1;
    end else begin
      sel_dcf_s = 1'b0;
    end
  end

  assign dcf_load_s = rd_s & sel_dcf_s & (word_s == WORD0);
  assign clk_load_s = rd_s & sel_clk_s & (word_s == WORD0);
  assign stat_clr_s = rd_s & sel_stat_s;

  dcf77_frame_snapshot #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .SEL_W  (SEL_W)
  ) u_dcf_snap (
    .clk      (clk),
    .rst      (rst),
    .load     (dcf_load_s),
    .frame_in (dcf77_frame_i),
    .word_sel (word_s),
    .word_out (dcf_word_s)
  );

  dcf77_frame_snapshot #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .SEL_W  (SEL_W)
  ) u_clk_snap (
    .clk      (clk),
    .rst      (rst),
    .load     (clk_load_s),
    .frame_in (clock_frame_i),
    .word_sel (word_s),
    .word_out (clk_word_s)
  );

  // Read mux: word 0 comes straight from the live input while the shadow captures it.
  always_comb begin
    rdata_s = '0;
    if (sel_dcf_s) begin
      if (word_s == WORD0) begin
        rdata_s = dcf77_frame_i[63 -: DATA_W];
      end else begin
        rdata_s = dcf_word_s;
      end
    end else if (sel_clk_s) begin
      if (word_s == WORD0) begin
        rdata_s = clock_frame_i[63 -: DATA_W];
      end else begin
        rdata_s = clk_word_s;
      end
    end else if (sel_stat_s) begin
      rdata_s[STAT_NEW_FRAME_BIT] = new_frame_r;
      rdata_s[STAT_OVERRUN_BIT]   = overrun_r;
    end else if (sel_ctrl_s) begin
      rdata_s[CTRL_IRQ_EN_BIT] = irq_en_s;
    end else begin
      rdata_s = '0;
    end
  end

  // Single-cycle ack with read data that holds between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
      dat_r <= '0;
    end else begin
      ack_r <= req_s;
      if (rd_s) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= dat_r;
      end
    end
  end

  // Sticky flags; a new pulse takes priority over a clearing STATUS read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_frame_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (dcf77_valid_i) begin
        new_frame_r <= 1'b1;
      end else if (stat_clr_s) begin
        new_frame_r <= 1'b0;
      end else begin
        new_frame_r <= new_frame_r;
      end
      if (dcf77_valid_i && new_frame_r) begin
        overrun_r <= 1'b1;
      end else if (stat_clr_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Sequential-read pointer: advances per read, wraps naturally, restarts on any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (AUTO_INC == 0) begin
      ptr_r <= '0;
    end else if (wr_s) begin
      ptr_r <= '0;
    end else if (rd_s) begin
      ptr_r <= ptr_r + SEL_W'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

`ifdef DCF77_REGFILE_IRQ_EN
  logic irq_en_r;
  logic irq_r;

  // Interrupt enable plus a registered copy of (new_frame & irq_en).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_s && sel_ctrl_s) begin
        irq_en_r <= wb_dat_i[CTRL_IRQ_EN_BIT];
      end else begin
        irq_en_r <= irq_en_r;
      end
      irq_r <= new_frame_r & irq_en_r;
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq_o    = irq_r;
`else
  assign irq_en_s = 1'b0;
`endif

  // Write data beyond the enable bit is architecturally ignored.
  assign unused_s = ^wb_dat_i;

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;

endmodule

// File: tb/tb_dcf77_regfile.sv
// Directed bench for dcf77_regfile: 8-bit addressed instance and 32-bit
// sequential-read instance, with hand-computed expected values.
module tb_dcf77_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_cyc, a_stb, a_we, a_ack;
  logic [4:0]  a_adr;
  logic [7:0]  a_wdat, a_dat;
  logic        b_cyc, b_stb, b_we, b_ack;
  logic [2:0]  b_adr;
  logic [31:0] b_wdat, b_dat;
  logic [63:0] dcf_frame, clk_frame;
  logic        valid;
`ifdef DCF77_REGFILE_IRQ_EN
  logic        a_irq, b_irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  rd8;
  logic [31:0] rd32;
  logic [7:0]  exp_a [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  always #5 clk = ~clk;

  dcf77_regfile #(.DATA_W(8), .AUTO_INC(0)) u_a (
    .clk(clk), .rst(rst),
    .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we),
    .wb_adr_i(a_adr), .wb_dat_i(a_wdat), .wb_dat_o(a_dat), .wb_ack_o(a_ack),
    .dcf77_frame_i(dcf_frame), .dcf77_valid_i(valid), .clock_frame_i(clk_frame)
`ifdef DCF77_REGFILE_IRQ_EN
    , .irq_o(a_irq)
`endif
  );

  dcf77_regfile #(.DATA_W(32), .AUTO_INC(1)) u_b (
    .clk(clk), .rst(rst),
    .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we),
    .wb_adr_i(b_adr), .wb_dat_i(b_wdat), .wb_dat_o(b_dat), .wb_ack_o(b_ack),
    .dcf77_frame_i(dcf_frame), .dcf77_valid_i(valid), .clock_frame_i(clk_frame)
`ifdef DCF77_REGFILE_IRQ_EN
    , .irq_o(b_irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance A; checks latency, single-cycle ack and data hold.
  task automatic a_xfer(input string tag, input logic we, input logic [4:0] adr,
                        input logic [7:0] wd, output logic [7:0] rd);
    int n;
    a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_adr = adr; a_wdat = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (a_ack !== 1'b1 && n < 20);
    check({tag, "_ack_lat"}, 32'(n), 32'd1);
    rd = a_dat;
    @(posedge clk); #1;
    check({tag, "_ack_low"}, 32'(a_ack), 32'd0);
    check({tag, "_dat_hold"}, 32'(a_dat), 32'(rd));
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_xfer(input string tag, input logic we, input logic [2:0] adr,
                        input logic [31:0] wd, output logic [31:0] rd);
    int n;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_wdat = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (b_ack !== 1'b1 && n < 20);
    check({tag, "_ack_lat"}, 32'(n), 32'd1);
    rd = b_dat;
    @(posedge clk); #1;
    check({tag, "_ack_low"}, 32'(b_ack), 32'd0);
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
  endtask

  task automatic pulse_valid();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0;
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_adr = 5'd0; a_wdat = 8'h00;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = 3'd0; b_wdat = 32'h0;
    dcf_frame = 64'h0123_4567_89AB_CDEF;
    clk_frame = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); @(posedge clk); #1;
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_a_dat", 32'(a_dat), 32'd0);
    check("rst_b_dat", b_dat, 32'h0);
`ifdef DCF77_REGFILE_IRQ_EN
    check("rst_irq", 32'(a_irq), 32'd0);
`endif
    rst = 1'b0;
    a_xfer("rst_status", 1'b0, 5'd16, 8'h00, rd8);
    check("rst_status_val", 32'(rd8), 32'h00);

    // Full frame read, MSB word first.
    for (int i = 0; i < 8; i++) begin
      a_xfer("dcf_rd", 1'b0, 5'(i), 8'h00, rd8);
      check("dcf_word", 32'(rd8), 32'(exp_a[i]));
    end

    // Coherence: input changes after word 0 must not affect words 1..7.
    a_xfer("coh_w0", 1'b0, 5'd0, 8'h00, rd8);
    check("coh_w0_val", 32'(rd8), 32'h01);
    dcf_frame = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 1; i < 8; i++) begin
      a_xfer("coh_rd", 1'b0, 5'(i), 8'h00, rd8);
      check("coh_word", 32'(rd8), 32'(exp_a[i]));
    end
    a_xfer("live_w0", 1'b0, 5'd0, 8'h00, rd8);
    check("live_w0_val", 32'(rd8), 32'hFF);

    // Clock frame region.
    a_xfer("clk_w0", 1'b0, 5'd8, 8'h00, rd8);
    check("clk_w0_val", 32'(rd8), 32'hFE);
    clk_frame = 64'h0;
    a_xfer("clk_w1", 1'b0, 5'd9, 8'h00, rd8);
    check("clk_w1_val", 32'(rd8), 32'hDC);
    a_xfer("clk_w7", 1'b0, 5'd15, 8'h00, rd8);
    check("clk_w7_val", 32'(rd8), 32'h10);

    // Sticky status: two pulses, clear, pulse during clearing read.
    pulse_valid();
    pulse_valid();
    a_xfer("stat1", 1'b0, 5'd16, 8'h00, rd8);
    check("stat1_val", 32'(rd8), 32'h03);
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 5'd16; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("stat2_ack", 32'(a_ack), 32'd1);
    check("stat2_val", 32'(a_dat), 32'h00);
    @(posedge clk); #1;
    check("stat2_ack_low", 32'(a_ack), 32'd0);
    a_cyc = 1'b0; a_stb = 1'b0;
    a_xfer("stat3", 1'b0, 5'd16, 8'h00, rd8);
    check("stat3_val", 32'(rd8), 32'h01);

    // Ignored writes and unmapped addresses.
    a_xfer("wr_frame", 1'b1, 5'd1, 8'h00, rd8);
    a_xfer("frame_after_wr", 1'b0, 5'd1, 8'h00, rd8);
    check("frame_after_wr_val", 32'(rd8), 32'hFF);
    a_xfer("oor20", 1'b0, 5'd20, 8'h00, rd8);
    check("oor20_val", 32'(rd8), 32'h00);
    a_xfer("oor31", 1'b0, 5'd31, 8'h00, rd8);
    check("oor31_val", 32'(rd8), 32'h00);
    pulse_valid();
    a_xfer("wr_status", 1'b1, 5'd16, 8'hFF, rd8);
    a_xfer("stat_after_wr", 1'b0, 5'd16, 8'h00, rd8);
    check("stat_after_wr_val", 32'(rd8), 32'h01);

    // CTRL register.
    a_xfer("wr_ctrl", 1'b1, 5'd17, 8'hFF, rd8);
    a_xfer("rd_ctrl", 1'b0, 5'd17, 8'h00, rd8);
`ifdef DCF77_REGFILE_IRQ_EN
    check("ctrl_val", 32'(rd8), 32'h01);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("irq_lag", 32'(a_irq), 32'd0);
    @(posedge clk); #1;
    check("irq_high", 32'(a_irq), 32'd1);
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 5'd16;
    @(posedge clk); #1;
    check("irq_stat_ack", 32'(a_ack), 32'd1);
    check("irq_stat_val", 32'(a_dat), 32'h01);
    check("irq_at_ack", 32'(a_irq), 32'd1);
    @(posedge clk); #1;
    check("irq_cleared", 32'(a_irq), 32'd0);
    a_cyc = 1'b0; a_stb = 1'b0;
`else
    check("ctrl_val", 32'(rd8), 32'h00);
`endif

    // Sequential-read instance: address ignored, pointer wraps, write restarts it.
    dcf_frame = 64'h0123_4567_89AB_CDEF;
    b_xfer("b_rd0", 1'b0, 3'd5, 32'h0, rd32);
    check("b_rd0_val", rd32, 32'h0123_4567);
    b_xfer("b_rd1", 1'b0, 3'd7, 32'h0, rd32);
    check("b_rd1_val", rd32, 32'h89AB_CDEF);
    b_xfer("b_rd2", 1'b0, 3'd3, 32'h0, rd32);
    check("b_rd2_val", rd32, 32'h0123_4567);
    b_xfer("b_rd3", 1'b0, 3'd0, 32'h0, rd32);
    check("b_rd3_val", rd32, 32'h89AB_CDEF);
    b_xfer("b_rd4", 1'b0, 3'd1, 32'h0, rd32);
    check("b_rd4_val", rd32, 32'h0123_4567);
    b_xfer("b_wr", 1'b1, 3'd6, 32'h0, rd32);
    b_xfer("b_rd5", 1'b0, 3'd1, 32'h0, rd32);
    check("b_rd5_val", rd32, 32'h0123_4567);

    // Reset during a pending access.
    a_xfer("pre_rst_w0", 1'b0, 5'd0, 8'h00, rd8);
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 5'd2;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(a_ack), 32'd1);
    check("pre_rst_dat", 32'(a_dat), 32'h45);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(a_ack), 32'd0);
    check("mid_rst_dat", 32'(a_dat), 32'd0);
    check("mid_rst_b_dat", b_dat, 32'h0);
    a_cyc = 1'b0; a_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    a_xfer("post_rst_w1", 1'b0, 5'd1, 8'h00, rd8);
    check("post_rst_w1_val", 32'(rd8), 32'h00);
    b_xfer("post_rst_b0", 1'b0, 3'd4, 32'h0, rd32);
    check("post_rst_b0_val", rd32, 32'h0123_4567);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
